piece_dropper: RTL

- Consumer of the new-shape generator in the falling-block game.
- Requests a fresh 145-bit shape bitmap by pulsing `refresh` and captures the shape one cycle later.
- Applies gravity ticks and left/right moves to the active piece, detects collisions against the locked board, and merges the piece into the board when it lands.
- Raises `game_over` when a freshly spawned piece overlaps the board.

---
 rtl/piece_dropper.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/piece_dropper.sv
// rtl/piece_dropper.sv - active-piece spawn, gravity, side moves, collision and board merge; define LINE_CLEAR_EN to add full-row clearing
module piece_dropper #(
  parameter int ROW_W = 12,
  parameter int ROWS  = 12
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         tick,
  input  logic         move_left,
  input  logic         move_right,
  input  logic [144:0] newShape,
  output logic         refresh,
  output logic [144:0] piece,
  output logic [144:0] board,
  output logic         game_over,
  output logic [7:0]   lines
);

  localparam int W     = 145;
  localparam int CELLS = ROW_W * ROWS;

  // kind 0: every playable cell, 1: column 0, 2: last column, 3: bottom row
  function automatic logic [W-1:0] make_mask(input int kind);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < CELLS; i++) begin
      case (kind)
        0:       m[i] = 1'b1;
        1:       m[i] = ((i % ROW_W) == 0);
        2:       m[i] = ((i % ROW_W) == ROW_W - 1);
        default: m[i] = (i >= (ROWS - 1) * ROW_W);
      endcase
    end
    return m;
  endfunction

  localparam logic [W-1:0] CELL_M   = make_mask(0);
  localparam logic [W-1:0] LEFT_M   = make_mask(1);
  localparam logic [W-1:0] RIGHT_M  = make_mask(2);
  localparam logic [W-1:0] BOTTOM_M = make_mask(3);

  typedef enum logic [2:0] {
    IDLE, REQ, LOAD, FALL, LOCK, OVER
`ifdef LINE_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   piece_n, board_n;
  logic           over_n;
  logic [W-1:0]   cand, down, to_left, to_right;

`ifdef LINE_CLEAR_EN
  localparam int RW = $clog2(ROWS);
  logic [RW-1:0]  row_q, row_n;
  logic [7:0]     lines_n;
  logic [W-1:0]   collapsed;
  logic           row_full;
`else
  assign lines = 8'd0;
`endif

  // next-state and next-value logic for the piece, board and game status
  always_comb begin
    state_n  = state;
    piece_n  = piece;
    board_n  = board;
    over_n   = game_over;
    cand     = newShape & CELL_M;
    down     = (piece << ROW_W) & CELL_M;
    to_left  = (piece >> 1) & CELL_M;
    to_right = (piece << 1) & CELL_M;
`ifdef LINE_CLEAR_EN
    lines_n  = lines;
    row_n    = row_q;
    row_full = &board[row_q*ROW_W +: ROW_W];
    // rows above the scanned row slide down one; row 0 always empties
    collapsed = board;
    collapsed[ROW_W-1:0] = '0;
    for (int i = 1; i < ROWS; i++) begin
      if (i <= int'(row_q)) collapsed[i*ROW_W +: ROW_W] = board[(i-1)*ROW_W +: ROW_W];
    end
`endif
    case (state)
      IDLE: begin
        if (start) begin
          board_n = '0;
          piece_n = '0;
          over_n  = 1'b0;
`ifdef LINE_CLEAR_EN
          lines_n = 8'd0;
`endif
          state_n = REQ;
        end
      end
      REQ: state_n = LOAD;
      LOAD: begin
        if (|(cand & board)) begin
          over_n  = 1'b1;
          state_n = OVER;
        end else begin
          piece_n = cand;
          state_n = FALL;
        end
      end
      FALL: begin
        // gravity wins over a same-cycle side move; edge checks run before shifting so rows never wrap
        if (tick) begin
          if ((|(piece & BOTTOM_M)) || (|(down & board))) state_n = LOCK;
          else piece_n = down;
        end else if (move_left && !move_right) begin
          if (!(|(piece & LEFT_M)) && !(|(to_left & board))) piece_n = to_left;
        end else if (move_right && !move_left) begin
          if (!(|(piece & RIGHT_M)) && !(|(to_right & board))) piece_n = to_right;
        end
      end
      LOCK: begin
        board_n = board | piece;
        piece_n = '0;
`ifdef LINE_CLEAR_EN
        row_n   = RW'(ROWS - 1);
        state_n = CLEAR;
`else
        state_n = REQ;
`endif
      end
`ifdef LINE_CLEAR_EN
      CLEAR: begin
        // a full row is removed and the same index rescanned, since a new row has dropped into it
        if (row_full) begin
          board_n = collapsed;
          lines_n = (lines == 8'hFF) ? lines : lines + 8'd1;
        end else if (row_q == '0) begin
          state_n = REQ;
        end else begin
          row_n = row_q - RW'(1);
        end
      end
`endif
      OVER: begin
        if (start) begin
          over_n  = 1'b0;
          board_n = '0;
`ifdef LINE_CLEAR_EN
          lines_n = 8'd0;
`endif
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and datapath registers; refresh is high for the single cycle spent in REQ
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      piece     <= '0;
      board     <= '0;
      game_over <= 1'b0;
      refresh   <= 1'b0;
    end else begin
      state     <= state_n;
      piece     <= piece_n;
      board     <= board_n;
      game_over <= over_n;
      refresh   <= (state_n == REQ);
    end
  end

`ifdef LINE_CLEAR_EN
  // row scan pointer and cleared-line counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_q <= '0;
      lines <= 8'd0;
    end else begin
      row_q <= row_n;
      lines <= lines_n;
    end
  end
`endif

endmodule
